// File: rtl/input_port_unit.sv
// Input port of the 5-port wormhole router: flit FIFO, XY route computation,
// wormhole route lock from head to tail, and registered forwarding to the crossbar.
module input_port_unit #(
   parameter int FLIT_W = 34,
   parameter int DEPTH  = 4,
   parameter int X_W    = 2,
   parameter int Y_W    = 2,
   parameter int CUR_X  = 0,
   parameter int CUR_Y  = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [FLIT_W-1:0] in_flit,
   output logic [4:0]        req,
   input  logic [4:0]        grant,
   output logic              out_valid,
   output logic [FLIT_W-1:0] out_flit,
   output logic [4:0]        out_port,
   output logic              err
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [X_W-1:0] CX = X_W'(CUR_X);
   localparam logic [Y_W-1:0] CY = Y_W'(CUR_Y);

   localparam logic [4:0] PORT_LOCAL = 5'b00001;
   localparam logic [4:0] PORT_NORTH = 5'b00010;
   localparam logic [4:0] PORT_EAST  = 5'b00100;
   localparam logic [4:0] PORT_SOUTH = 5'b01000;
   localparam logic [4:0] PORT_WEST  = 5'b10000;

   typedef enum logic {IDLE, ACTIVE} state_t;

   logic [FLIT_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr, rd_ptr;
   logic [AW:0]       count;
   logic              empty, full, push, pop;

   logic [FLIT_W-1:0] front;
   logic [1:0]        front_type;
   logic              front_is_head, front_is_tail;
   logic [X_W-1:0]    dest_x;
   logic [Y_W-1:0]    dest_y;
   logic [4:0]        route;

   state_t            state, state_nxt;
   logic [4:0]        port_q, port_nxt;
   logic              pop_en, drop, err_set;

   assign empty    = (count == '0);
   assign full     = (count == (AW+1)'(DEPTH));
   assign in_ready = !full;
   assign push     = in_valid && in_ready;
   assign pop      = pop_en || drop;

   assign front         = mem[rd_ptr];
   assign front_type    = front[FLIT_W-1:FLIT_W-2];
   // type bit 0 marks a head (01/11), bit 1 marks a tail (10/11)
   assign front_is_head = front_type[0];
   assign front_is_tail = front_type[1];
   assign dest_x        = front[X_W-1:0];
   assign dest_y        = front[X_W+Y_W-1:X_W];

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= in_flit;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   always_comb begin
      route = PORT_LOCAL;
      if (dest_x > CX) begin
         route = PORT_EAST;
      end else if (dest_x < CX) begin
         route = PORT_WEST;
      end else if (dest_y > CY) begin
         route = PORT_NORTH;
      end else if (dest_y < CY) begin
         route = PORT_SOUTH;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         port_q <= '0;
      end else begin
         state  <= state_nxt;
         port_q <= port_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      port_nxt  = port_q;
      req       = '0;
      pop_en    = 1'b0;
      drop      = 1'b0;
      err_set   = 1'b0;
      case (state)
         IDLE: begin
            if (|grant) begin
               err_set = 1'b1;
            end
            if (!empty) begin
               if (front_is_head) begin
                  port_nxt  = route;
                  state_nxt = ACTIVE;
               end else begin
                  drop    = 1'b1;
                  err_set = 1'b1;
               end
            end
         end
         ACTIVE: begin
            if (!empty) begin
               req = port_q;
            end
            // a grant from an output this packet never requested is a protocol error
            if (|(grant & ~port_q)) begin
               err_set = 1'b1;
            end
            if (|(grant & port_q)) begin
               if (empty) begin
                  err_set = 1'b1;
               end else begin
                  pop_en = 1'b1;
                  if (front_is_tail) begin
                     state_nxt = IDLE;
                  end
               end
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_flit  <= '0;
         out_port  <= '0;
         err       <= 1'b0;
      end else begin
         out_valid <= pop_en;
         if (pop_en) begin
            out_flit <= front;
            out_port <= port_q;
         end
         if (err_set) begin
            err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_input_port_unit.sv
// Directed, table-driven bench for input_port_unit at router coordinate (1,1):
// each record drives one cycle of inputs and lists the outputs expected after that edge.
module tb_input_port_unit;

   localparam int FW = 34;

   localparam logic [4:0] L = 5'b00001;
   localparam logic [4:0] N = 5'b00010;
   localparam logic [4:0] E = 5'b00100;
   localparam logic [4:0] S = 5'b01000;
   localparam logic [4:0] W = 5'b10000;

   localparam logic [1:0] TB = 2'b00;
   localparam logic [1:0] TH = 2'b01;
   localparam logic [1:0] TT = 2'b10;
   localparam logic [1:0] HT = 2'b11;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [FW-1:0] in_flit = '0;
   logic [4:0]    req;
   logic [4:0]    grant = '0;
   logic          out_valid;
   logic [FW-1:0] out_flit;
   logic [4:0]    out_port;
   logic          err;

   int checks = 0;
   int errors = 0;
   int vec_idx = -1;

   input_port_unit #(.FLIT_W(FW), .DEPTH(4), .X_W(2), .Y_W(2), .CUR_X(1), .CUR_Y(1)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_flit(in_flit),
      .req(req), .grant(grant), .out_valid(out_valid), .out_flit(out_flit),
      .out_port(out_port), .err(err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic          rst;
      logic          iv;
      logic [FW-1:0] fl;
      logic [4:0]    gr;
      logic [4:0]    req;
      logic          ov;
      logic [FW-1:0] of;
      logic [4:0]    op;
      logic          ir;
      logic          er;
   } vec_t;

   vec_t vecs[$];

   function automatic logic [FW-1:0] fl(input logic [1:0] t, input int p);
      return {t, 32'(p)};
   endfunction

   function automatic logic [FW-1:0] hd(input logic [1:0] t, input int x, input int y, input int tag);
      return {t, 28'(tag), 2'(y), 2'(x)};
   endfunction

   task automatic add(input logic r, input logic iv, input logic [FW-1:0] f, input logic [4:0] g,
                      input logic [4:0] rq, input logic ov, input logic [FW-1:0] of,
                      input logic [4:0] op, input logic ir, input logic er);
      vec_t v;
      v.rst = r; v.iv = iv; v.fl = f; v.gr = g;
      v.req = rq; v.ov = ov; v.of = of; v.op = op; v.ir = ir; v.er = er;
      vecs.push_back(v);
   endtask

   task automatic chk(input string nm, input logic [FW-1:0] act, input logic [FW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s vec %0d: got %h expected %h", nm, vec_idx, act, exp);
      end
   endtask

   logic [FW-1:0] f1, p0, p1, p2, p3, q0, q1, q2, q3, xr, r0, r1, b0, g0, c0;
   logic [FW-1:0] k0, k1, k2, k3, d0, d1;

   initial begin
      f1 = hd(HT, 3, 1, 'h11);
      p0 = hd(TH, 1, 0, 'h20); p1 = fl(TB, 'h21); p2 = fl(TB, 'h22); p3 = fl(TT, 'h23);
      q0 = hd(TH, 2, 1, 'h30); q1 = fl(TB, 'h31); q2 = fl(TB, 'h32); q3 = fl(TT, 'h33);
      xr = hd(HT, 0, 0, 'h3f); r0 = hd(HT, 1, 1, 'h40); r1 = hd(HT, 0, 1, 'h41);
      b0 = fl(TB, 'h50);       g0 = hd(HT, 0, 0, 'h51); c0 = hd(HT, 1, 1, 'h60);
      k0 = hd(TH, 1, 2, 'h70); k1 = fl(TB, 'h71); k2 = fl(TB, 'h72); k3 = fl(TT, 'h73);
      d0 = hd(TH, 1, 0, 'h80); d1 = fl(TT, 'h81);

      // single head+tail flit to (3,1): east
      add(0, 1, f1, 0,  0, 0, 0,  0, 1, 0);
      add(0, 0, 0,  0,  E, 0, 0,  0, 1, 0);
      add(0, 0, 0,  E,  0, 1, f1, E, 1, 0);
      add(0, 0, 0,  0,  0, 0, 0,  0, 1, 0);
      // 4-flit packet to (1,0): south, grant alternating
      add(0, 1, p0, 0,  0, 0, 0,  0, 1, 0);
      add(0, 1, p1, 0,  S, 0, 0,  0, 1, 0);
      add(0, 1, p2, S,  S, 1, p0, S, 1, 0);
      add(0, 1, p3, 0,  S, 0, 0,  0, 1, 0);
      add(0, 0, 0,  S,  S, 1, p1, S, 1, 0);
      add(0, 0, 0,  0,  S, 0, 0,  0, 1, 0);
      add(0, 0, 0,  S,  S, 1, p2, S, 1, 0);
      add(0, 0, 0,  0,  S, 0, 0,  0, 1, 0);
      add(0, 0, 0,  S,  0, 1, p3, S, 1, 0);
      add(0, 0, 0,  0,  0, 0, 0,  0, 1, 0);
      // fill FIFO, backpressure, push+pop together, then local and west packets
      add(0, 1, q0, 0,  0, 0, 0,  0, 1, 0);
      add(0, 1, q1, 0,  E, 0, 0,  0, 1, 0);
      add(0, 1, q2, 0,  E, 0, 0,  0, 1, 0);
      add(0, 1, q3, 0,  E, 0, 0,  0, 0, 0);
      add(0, 1, xr, 0,  E, 0, 0,  0, 0, 0);
      add(0, 0, 0,  E,  E, 1, q0, E, 1, 0);
      add(0, 1, r0, E,  E, 1, q1, E, 1, 0);
      add(0, 1, r1, 0,  E, 0, 0,  0, 0, 0);
      add(0, 0, 0,  E,  E, 1, q2, E, 1, 0);
      add(0, 0, 0,  E,  0, 1, q3, E, 1, 0);
      add(0, 0, 0,  0,  L, 0, 0,  0, 1, 0);
      add(0, 0, 0,  L,  0, 1, r0, L, 1, 0);
      add(0, 0, 0,  0,  W, 0, 0,  0, 1, 0);
      add(0, 0, 0,  W,  0, 1, r1, W, 1, 0);
      add(0, 0, 0,  0,  0, 0, 0,  0, 1, 0);
      // orphan body flit dropped in IDLE, following head still routes
      add(0, 1, b0, 0,  0, 0, 0,  0, 1, 0);
      add(0, 1, g0, 0,  0, 0, 0,  0, 1, 1);
      add(0, 0, 0,  0,  W, 0, 0,  0, 1, 1);
      add(0, 0, 0,  W,  0, 1, g0, W, 1, 1);
      add(0, 0, 0,  0,  0, 0, 0,  0, 1, 1);
      // local destination, grant from the wrong output
      add(1, 0, 0,  0,  0, 0, 0,  0, 1, 0);
      add(0, 1, c0, 0,  0, 0, 0,  0, 1, 0);
      add(0, 0, 0,  0,  L, 0, 0,  0, 1, 0);
      add(0, 0, 0,  N,  L, 0, 0,  0, 1, 1);
      add(0, 0, 0,  L,  0, 1, c0, L, 1, 1);
      // reset mid-packet, then a grant while IDLE
      add(1, 0, 0,  0,  0, 0, 0,  0, 1, 0);
      add(0, 1, k0, 0,  0, 0, 0,  0, 1, 0);
      add(0, 1, k1, 0,  N, 0, 0,  0, 1, 0);
      add(0, 1, k2, N,  N, 1, k0, N, 1, 0);
      add(0, 1, k3, N,  N, 1, k1, N, 1, 0);
      add(1, 0, 0,  0,  0, 0, 0,  0, 1, 0);
      add(0, 0, 0,  0,  0, 0, 0,  0, 1, 0);
      add(0, 0, 0,  N,  0, 0, 0,  0, 1, 1);
      // route lock held across an empty gap; grant while empty is an error
      add(1, 0, 0,  0,  0, 0, 0,  0, 1, 0);
      add(0, 1, d0, 0,  0, 0, 0,  0, 1, 0);
      add(0, 0, 0,  0,  S, 0, 0,  0, 1, 0);
      add(0, 0, 0,  S,  0, 1, d0, S, 1, 0);
      add(0, 0, 0,  S,  0, 0, 0,  0, 1, 1);
      add(0, 1, d1, 0,  S, 0, 0,  0, 1, 1);
      add(0, 0, 0,  S,  0, 1, d1, S, 1, 1);
      add(0, 0, 0,  0,  0, 0, 0,  0, 1, 1);

      // initial reset values
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready",  FW'(in_ready),  FW'(1'b1));
      chk("rst_req",       FW'(req),       '0);
      chk("rst_out_valid", FW'(out_valid), '0);
      chk("rst_out_flit",  out_flit,       '0);
      chk("rst_out_port",  FW'(out_port),  '0);
      chk("rst_err",       FW'(err),       '0);

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         rst      = vecs[i].rst;
         in_valid = vecs[i].iv;
         in_flit  = vecs[i].fl;
         grant    = vecs[i].gr;
         @(posedge clk);
         #1;
         vec_idx = i;
         chk("req",       FW'(req),       FW'(vecs[i].req));
         chk("out_valid", FW'(out_valid), FW'(vecs[i].ov));
         chk("in_ready",  FW'(in_ready),  FW'(vecs[i].ir));
         chk("err",       FW'(err),       FW'(vecs[i].er));
         if (vecs[i].ov || vecs[i].rst) begin
            chk("out_flit", out_flit,      vecs[i].of);
            chk("out_port", FW'(out_port), FW'(vecs[i].op));
         end
      end

      @(negedge clk);
      in_valid = 1'b0;
      grant    = '0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
